// File: rtl/i2c_master_fsm.sv
// I2C master byte sequencer: START, address/rw frame, write/read bytes, ACK handling, STOP.
// Optional macro I2C_NACK_ABORT_EN: a slave NACK forces the transaction to STOP.
module i2c_master_fsm #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_clk,
  input  logic              ena,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [7:0]        data_wr,
  input  logic              sda_in,
  output logic              sda_drv_low,
  output logic              scl_not_ena,
  output logic              busy,
  output logic [7:0]        data_rd,
  output logic              rd_valid,
  output logic              ack_error
);

  localparam int CNT_W = (ADDR_W > 7) ? $clog2(ADDR_W + 1) : 3;

  typedef enum logic [3:0] {IDLE, START, CMD, SACK1, WR, RD, SACK2, MACK, STOP} state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W:0]    cmd_reg, cmd_next;
  logic [7:0]         wr_reg, wr_next;
  logic [7:0]         rx_reg, rx_next;
  logic [7:0]         rd_reg, rd_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_dec;
  logic               dclk_prev_reg;
  logic               sda_reg, sda_next;
  logic               scl_reg, scl_next;
  logic               busy_reg, busy_next;
  logic               ack_err_reg, ack_err_next;
  logic               rdv_reg, rdv_next;
  logic               rise, fall, same_cmd, nack_abort;

  assign rise     = data_clk & ~dclk_prev_reg;
  assign fall     = ~data_clk & dclk_prev_reg;
  assign same_cmd = ena && ({addr, rw} == cmd_reg);
  assign cnt_dec  = cnt_reg - 1'b1;

`ifdef I2C_NACK_ABORT_EN
  // ack_error is cleared at START, so it only reflects NACKs of the current transaction.
  assign nack_abort = ack_err_reg;
`else
  assign nack_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cmd_reg       <= '0;
      wr_reg        <= '0;
      rx_reg        <= '0;
      rd_reg        <= '0;
      cnt_reg       <= CNT_W'(ADDR_W);
      dclk_prev_reg <= 1'b0;
      sda_reg       <= 1'b0;
      scl_reg       <= 1'b1;
      busy_reg      <= 1'b0;
      ack_err_reg   <= 1'b0;
      rdv_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cmd_reg       <= cmd_next;
      wr_reg        <= wr_next;
      rx_reg        <= rx_next;
      rd_reg        <= rd_next;
      cnt_reg       <= cnt_next;
      dclk_prev_reg <= data_clk;
      sda_reg       <= sda_next;
      scl_reg       <= scl_next;
      busy_reg      <= busy_next;
      ack_err_reg   <= ack_err_next;
      rdv_reg       <= rdv_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cmd_next     = cmd_reg;
    wr_next      = wr_reg;
    rx_next      = rx_reg;
    rd_next      = rd_reg;
    cnt_next     = cnt_reg;
    sda_next     = sda_reg;
    scl_next     = scl_reg;
    busy_next    = busy_reg;
    ack_err_next = ack_err_reg;
    rdv_next     = 1'b0;

    // Falling edges sample the bus; rising edges advance the sequence.
    if (fall) begin
      scl_next = (state_reg == IDLE) || (state_reg == STOP);
      if (state_reg == RD)
        rx_next = {rx_reg[6:0], sda_in};
      if (((state_reg == SACK1) || (state_reg == SACK2)) && sda_in)
        ack_err_next = 1'b1;
    end

    if (rise) begin
      unique case (state_reg)
        IDLE: begin
          if (ena) begin
            cmd_next   = {addr, rw};
            wr_next    = data_wr;
            busy_next  = 1'b1;
            sda_next   = 1'b1;
            state_next = START;
          end else begin
            busy_next  = 1'b0;
          end
        end
        START: begin
          ack_err_next = 1'b0;
          cnt_next     = CNT_W'(ADDR_W);
          sda_next     = ~cmd_reg[ADDR_W];
          state_next   = CMD;
        end
        CMD: begin
          if (cnt_reg == '0) begin
            sda_next   = 1'b0;
            state_next = SACK1;
          end else begin
            cnt_next   = cnt_dec;
            sda_next   = ~cmd_reg[cnt_dec];
          end
        end
        SACK1: begin
          cnt_next = CNT_W'(7);
          if (nack_abort) begin
            sda_next   = 1'b1;
            state_next = STOP;
          end else if (!cmd_reg[0]) begin
            sda_next   = ~wr_reg[7];
            state_next = WR;
          end else begin
            sda_next   = 1'b0;
            state_next = RD;
          end
        end
        WR: begin
          if (cnt_reg == '0) begin
            sda_next   = 1'b0;
            state_next = SACK2;
          end else begin
            cnt_next   = cnt_dec;
            sda_next   = ~wr_reg[cnt_dec[2:0]];
          end
        end
        RD: begin
          if (cnt_reg == '0) begin
            rd_next    = rx_reg;
            rdv_next   = 1'b1;
            sda_next   = same_cmd;   // ACK only when another byte is wanted
            state_next = MACK;
          end else begin
            cnt_next   = cnt_dec;
          end
        end
        SACK2, MACK: begin
          if ((state_reg == SACK2) && nack_abort) begin
            sda_next   = 1'b1;
            state_next = STOP;
          end else if (same_cmd) begin
            cnt_next = CNT_W'(7);
            if (state_reg == SACK2) begin
              wr_next    = data_wr;
              sda_next   = ~data_wr[7];
              state_next = WR;
            end else begin
              sda_next   = 1'b0;
              state_next = RD;
            end
          end else if (ena) begin
            cmd_next   = {addr, rw};
            wr_next    = data_wr;
            sda_next   = 1'b1;
            state_next = START;
          end else begin
            sda_next   = 1'b1;
            state_next = STOP;
          end
        end
        STOP: begin
          sda_next   = 1'b0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign sda_drv_low = sda_reg;
  assign scl_not_ena = scl_reg;
  assign busy        = busy_reg;
  assign data_rd     = rd_reg;
  assign rd_valid    = rdv_reg;
  assign ack_error   = ack_err_reg;

endmodule
